// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: WB control word layout,
// writeback source encodings and register index width.
// No logic; constants and a small decode helper only.
package wb_pkg;

    // Register index width (64 architectural registers)
    localparam int RIDX_W = 6;

    // Bit positions inside the 7-bit WB control word
    localparam int WB_REGWRITE  = 0;
    localparam int WB_SRC_LSB   = 1;
    localparam int WB_SRC_MSB   = 2;
    localparam int WB_FLAGWRITE = 3;

    // Writeback source encodings (2'b11 falls back to the ALU result)
    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_DMEM = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;

    // Extract the source-select field from a WB control word
    function automatic logic [1:0] wb_src(input logic [6:0] wb);
        return wb[WB_SRC_MSB:WB_SRC_LSB];
    endfunction

endpackage

// File: rtl/regfile_64x32.sv
// Purpose: register storage, one synchronous write port, two async read ports, no bypass.
// Latency: write commits at the clock edge; reads are combinational from storage.
// Backpressure: none; a write can be accepted every cycle.
module regfile_64x32
    import wb_pkg::*;
#(
    parameter int NREGS = 64,
    parameter int DW    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [RIDX_W-1:0] raddr1,
    input  logic [RIDX_W-1:0] raddr2,
    output logic [DW-1:0]     rdata1,
    output logic [DW-1:0]     rdata2
);

    logic [DW-1:0] mem [NREGS];

    // Storage update: reset clears every entry and takes priority over a write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Purpose: writeback stage; selects the WB value, commits it to the regfile, latches N/Z flags.
// Latency: register write visible in the same cycle via bypass; flags visible one cycle later.
// Backpressure: none; one instruction per cycle, bubbles arrive as iWB=0.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int NREGS = 64,
    parameter int DW    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DW-1:0]     iDMEM,
    input  logic [DW-1:0]     iALU,
    input  logic [DW-1:0]     iI,
    input  logic [RIDX_W-1:0] iRd,
    input  logic [6:0]        iWB,
    input  logic              iN,
    input  logic              iZ,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    output logic [DW-1:0]     rd1,
    output logic [DW-1:0]     rd2,
    output logic              oN,
    output logic              oZ,
    output logic [DW-1:0]     oWData
);

    logic          reg_write;
    logic          flag_write;
    logic [DW-1:0] store1;
    logic [DW-1:0] store2;
    logic          hit1;
    logic          hit2;

    // Reserved control bits are deliberately never decoded
    logic          unused_rsvd;
    assign unused_rsvd = ^iWB[6:4];

    assign reg_write  = iWB[WB_REGWRITE];
    assign flag_write = iWB[WB_FLAGWRITE];

    // Writeback source mux; driven whether or not the register write is enabled
    always_comb begin
        oWData = iALU;
        case (wb_src(iWB))
            SRC_DMEM: oWData = iDMEM;
            SRC_IMM:  oWData = iI;
            default:  oWData = iALU;
        endcase
    end

    regfile_64x32 #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_rf (
        .clock  (clock),
        .reset  (reset),
        .we     (reg_write),
        .waddr  (iRd),
        .wdata  (oWData),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (store1),
        .rdata2 (store2)
    );

    // Same-cycle bypass; intentionally not gated by reset so decode sees the in-flight value
    always_comb begin
        hit1 = reg_write && (rs1 == iRd);
        hit2 = reg_write && (rs2 == iRd);
        rd1  = hit1 ? oWData : store1;
        rd2  = hit2 ? oWData : store2;
    end

    // Architectural flag register; reset wins over a simultaneous flag write
    always_ff @(posedge clock) begin
        if (reset) begin
            oN <= 1'b0;
            oZ <= 1'b0;
        end else if (flag_write) begin
            oN <= iN;
            oZ <= iZ;
        end
    end

endmodule
